// File: rtl/tdm_demux16.sv
// tdm_demux16 - receive-side demultiplexer for a 16-slot TDM serial stream.
//
// A slot counter stands in for the transmit mux select. Each valid bit is
// written into a shadow register at the current slot. When the slot-15 bit
// arrives, the whole frame is published on `out` with a one-cycle strobe.
// A HUNT/SYNC state machine tracks frame alignment. When frame_sync and the
// slot counter disagree, the block reports the error and recovers.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (priority over all inputs)
//   din          serial TDM data bit
//   din_valid    din/frame_sync are meaningful this cycle (gaps allowed)
//   frame_sync   marks din as slot 0 (ignored when din_valid=0)
//   out          last complete frame, out[k] = channel k
//   frame_valid  one-cycle pulse when out updates
//   slot         slot index the next valid bit will be written to
//   locked       high while in SYNC
//   sync_err     one-cycle pulse on an alignment error
//   err_cnt      saturating count of alignment errors
module tdm_demux16 #(
  parameter int N_CH  = 16,
  parameter int SEL_W = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [N_CH-1:0]  out,
  output logic             frame_valid,
  output logic [SEL_W-1:0] slot,
  output logic             locked,
  output logic             sync_err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {HUNT = 1'b0, SYNC = 1'b1} state_t;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);

  // Error counter sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [SEL_W-1:0] slot_q, slot_d;
  logic [N_CH-1:0]  shadow_q, shadow_d;
  logic [N_CH-1:0]  out_q, out_d;
  logic             fv_q, fv_d;
  logic             serr_q, serr_d;
  logic [ERR_W-1:0] err_q, err_d;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    fv_d     = 1'b0;
    serr_d   = 1'b0;
    err_d    = err_q;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          // Anything before the first frame_sync is noise and is dropped.
          if (frame_sync) begin
            shadow_d    = '0;
            shadow_d[0] = din;
            slot_d      = SEL_W'(1);
            state_d     = SYNC;
          end
        end
        SYNC: begin
          if (frame_sync && (slot_q != '0)) begin
            // Early sync: abandon the partial frame and realign on this bit.
            serr_d      = 1'b1;
            err_d       = sat_inc(err_q);
            shadow_d    = '0;
            shadow_d[0] = din;
            slot_d      = SEL_W'(1);
          end else if (!frame_sync && (slot_q == '0)) begin
            // Missing sync at a frame boundary: alignment is lost.
            serr_d  = 1'b1;
            err_d   = sat_inc(err_q);
            state_d = HUNT;
          end else if (slot_q == LAST_SLOT) begin
            out_d    = {din, shadow_q[N_CH-2:0]};
            fv_d     = 1'b1;
            slot_d   = '0;
            shadow_d = '0;
          end else begin
            shadow_d[slot_q] = din;
            slot_d           = slot_q + SEL_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      shadow_q <= '0;
      out_q    <= '0;
      fv_q     <= 1'b0;
      serr_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      fv_q     <= fv_d;
      serr_q   <= serr_d;
      err_q    <= err_d;
    end
  end

  assign out         = out_q;
  assign frame_valid = fv_q;
  assign slot        = slot_q;
  assign locked      = (state_q == SYNC);
  assign sync_err    = serr_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_tdm_demux16.sv
// Testbench for tdm_demux16: a driver applies stimulus one cycle at a time.
// For each cycle, a frame-level reference model predicts the visible outputs
// after the clock edge and queues that prediction. A monitor pops the
// prediction just after each edge and compares it with the DUT outputs.
module tb_tdm_demux16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        frame_sync = 1'b0;
  logic [15:0] out;
  logic        frame_valid;
  logic [3:0]  slot;
  logic        locked;
  logic        sync_err;
  logic [7:0]  err_cnt;

  tdm_demux16 dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .out(out), .frame_valid(frame_valid),
    .slot(slot), .locked(locked), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] out;
    logic        fv;
    logic [3:0]  slot;
    logic        locked;
    logic        serr;
    logic [7:0]  err;
  } exp_t;

  exp_t expq[$];

  // Reference model: frame in progress kept as a list of received bits.
  bit          m_locked;
  bit          m_frame[$];
  int          m_err;
  logic [15:0] m_out;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_error();
    if (m_err < 255) m_err++;
  endtask

  // Drive one cycle and queue the expected outputs after the coming edge.
  task automatic step(input bit r, input bit v, input bit fs, input bit d);
    exp_t e;
    logic [15:0] w;
    @(negedge clk);
    rst = r; din_valid = v; frame_sync = fs; din = d;
    e.fv = 1'b0;
    e.serr = 1'b0;
    if (r) begin
      m_locked = 0; m_frame.delete(); m_err = 0; m_out = '0;
    end else if (v) begin
      if (!m_locked) begin
        if (fs) begin
          m_locked = 1; m_frame.delete(); m_frame.push_back(d);
        end
      end else if (fs) begin
        if (m_frame.size() != 0) begin
          e.serr = 1'b1; model_error();
        end
        m_frame.delete(); m_frame.push_back(d);
      end else if (m_frame.size() == 0) begin
        e.serr = 1'b1; model_error(); m_locked = 0;
      end else begin
        m_frame.push_back(d);
        if (m_frame.size() == 16) begin
          w = '0;
          for (int k = 0; k < 16; k++) if (m_frame[k]) w = w | (16'd1 << k);
          m_out = w; e.fv = 1'b1; m_frame.delete();
        end
      end
    end
    e.out    = m_out;
    e.slot   = m_locked ? 4'(m_frame.size()) : 4'd0;
    e.locked = m_locked;
    e.err    = 8'(m_err);
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // Send bits [first..15] of a frame, optionally with a gap before bit gap_at.
  task automatic send_frame(input logic [15:0] w, input int gap_at, input int gap_len);
    for (int k = 0; k < 16; k++) begin
      if (k == gap_at) idle(gap_len);
      step(0, 1, k == 0, w[k]);
    end
  endtask

  task automatic send_partial(input logic [15:0] w, input int nbits);
    for (int k = 0; k < nbits; k++) step(0, 1, k == 0, w[k]);
  endtask

  exp_t me;
  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      me = expq.pop_front();
      chk("out",         32'(out),         32'(me.out));
      chk("frame_valid", 32'(frame_valid), 32'(me.fv));
      chk("slot",        32'(slot),        32'(me.slot));
      chk("locked",      32'(locked),      32'(me.locked));
      chk("sync_err",    32'(sync_err),    32'(me.serr));
      chk("err_cnt",     32'(err_cnt),     32'(me.err));
    end
  end

  initial begin
    bit fs;
    // 1: reset then a clean frame
    step(1, 0, 0, 0); step(1, 1, 1, 1);
    send_frame(16'hA5C3, -1, 0);
    idle(2);
    // 2: same frame with a 3-cycle gap between slots 7 and 8
    send_frame(16'hA5C3, 8, 3);
    idle(1);
    // 3: back-to-back frames
    send_frame(16'h0001, -1, 0);
    send_frame(16'h8000, -1, 0);
    idle(2);
    // 4: early sync at slot 6, then a full new frame starting there
    step(1, 0, 0, 0);
    send_partial(16'hFFFF, 6);
    send_frame(16'h3C5A, -1, 0);
    idle(2);
    // 5: missing sync after a good frame, ignored bits, then resume
    step(1, 0, 0, 0);
    send_frame(16'h1234, -1, 0);
    step(0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1'($urandom_range(0, 1)));
    send_frame(16'hBEEF, -1, 0);
    idle(2);
    // 6: reset mid-frame at slot 9, then saturate the error counter
    send_partial(16'h5555, 9);
    step(1, 1, 0, 1);
    idle(2);
    for (int i = 0; i < 300; i++) begin
      send_frame(16'($urandom), -1, 0);
      step(0, 1, 0, 1'($urandom_range(0, 1)));
    end
    idle(2);
    // Randomized traffic with gaps, stray syncs and occasional reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        if (m_locked && m_frame.size() != 0) fs = ($urandom_range(0, 39) == 0);
        else fs = ($urandom_range(0, 7) != 0);
        step(0, $urandom_range(0, 3) != 0, fs, 1'($urandom_range(0, 1)));
      end
    end
    idle(3);
    @(posedge clk); #3;
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
